// File: rtl/alu_pkg.sv
// Shared definitions for the ALU opcode sequencer: opcodes,
// instruction field offsets and the sequencer state type.
package alu_pkg;

    localparam int ALU_DW = 4;
    localparam int ALU_RW = 2;
    localparam int ALU_IW = 4 + 3 * ALU_RW + 2 + ALU_DW;

    localparam logic [3:0] OP_NOT  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_XNOR = 4'h6;
    localparam logic [3:0] OP_MUL  = 4'h7;
    localparam logic [3:0] OP_DIV  = 4'h8;
    localparam logic [3:0] OP_SHL1 = 4'h9;
    localparam logic [3:0] OP_SHR1 = 4'hA;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_DEC  = 4'hC;
    localparam logic [3:0] OP_LAST = 4'hC;

    localparam int F_IMM_LSB = 0;
    localparam int F_CIN_BIT = ALU_DW;
    localparam int F_UIMM_BIT = ALU_DW + 1;
    localparam int F_RB_LSB = ALU_DW + 2;
    localparam int F_RA_LSB = ALU_DW + 2 + ALU_RW;
    localparam int F_RD_LSB = ALU_DW + 2 + 2 * ALU_RW;
    localparam int F_OP_LSB = ALU_DW + 2 + 3 * ALU_RW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file: two combinational read ports, a debug read
// port and one synchronous write port, cleared by async reset.
module alu_seq_regfile #(
    parameter int DW = 4,
    parameter int RW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [RW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [RW-1:0] i_raddr_a,
    input  logic [RW-1:0] i_raddr_b,
    input  logic [RW-1:0] i_dbg_sel,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [2**RW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**RW; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_sel];

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the 4-bit ALU opcode interface: accepts an
// instruction, drives the external ALU, writes back and responds.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = ALU_RW,
    localparam int IW = 4 + 3 * RW + 2 + DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    output logic [3:0]    alu_f,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] alu_cin,
    input  logic [DW-1:0] alu_d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_err,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data
);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_f;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_cin;
    logic [DW-1:0] r_data;
    logic [RW-1:0] r_rd;
    logic          r_err;

    logic [3:0]    w_op;
    logic [RW-1:0] w_rd;
    logic [RW-1:0] w_ra;
    logic [RW-1:0] w_rb;
    logic          w_uimm;
    logic          w_cin;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_rda;
    logic [DW-1:0] w_rdb;
    logic [DW-1:0] w_opb;
    logic          w_rej;
    logic          w_acc;
    logic          w_we;

    assign w_op   = in_instr[F_OP_LSB +: 4];
    assign w_rd   = in_instr[F_RD_LSB +: RW];
    assign w_ra   = in_instr[F_RA_LSB +: RW];
    assign w_rb   = in_instr[F_RB_LSB +: RW];
    assign w_uimm = in_instr[F_UIMM_BIT];
    assign w_cin  = in_instr[F_CIN_BIT];
    assign w_imm  = in_instr[F_IMM_LSB +: DW];

    assign w_opb = w_uimm ? w_imm : w_rdb;
    // Illegal opcodes and divide-by-zero never reach the ALU
    assign w_rej = (w_op > OP_LAST) || ((w_op == OP_DIV) && (w_opb == '0));
    assign w_acc = in_valid && (r_state == S_IDLE);

    alu_seq_regfile #(
        .DW(DW),
        .RW(RW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (r_rd),
        .i_wdata   (alu_d),
        .i_raddr_a (w_ra),
        .i_raddr_b (w_rb),
        .i_dbg_sel (dbg_sel),
        .o_rdata_a (w_rda),
        .o_rdata_b (w_rdb),
        .o_dbg_data(dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = w_rej ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_we      = 1'b0;
        unique case (r_state)
            S_IDLE:    in_ready  = 1'b1;
            S_CAPTURE: w_we      = 1'b1;
            S_RESP:    out_valid = 1'b1;
            default:   in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cin  <= '0;
            r_data <= '0;
            r_rd   <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_rd <= w_rd;
                if (w_rej) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_err <= 1'b0;
                    r_f   <= w_op;
                    r_a   <= w_rda;
                    r_b   <= w_opb;
                    r_cin <= {{(DW-1){1'b0}}, w_cin};
                end
            end
            if (r_state == S_CAPTURE) begin
                r_data <= alu_d;
            end
        end
    end

    assign alu_f    = r_f;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_cin  = r_cin;
    assign out_data = r_data;
    assign out_rd   = r_rd;
    assign out_err  = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural 4-bit ALU alongside;
// directed vector table plus backpressure and mid-op reset sequences.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [3:0]  alu_f;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_cin;
    logic [3:0]  alu_d;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_rd;
    logic        out_err;
    logic [1:0]  dbg_sel;
    logic [3:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  f;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  cin;
        logic [3:0]  data;
        logic [1:0]  rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t       vt [18];
    logic [3:0] m_reg [4];

    alu_op_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .alu_f    (alu_f),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_d    (alu_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_rd   (out_rd),
        .out_err  (out_err),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // Behavioural model of the external combinational ALU
    always_comb begin
        alu_d = 4'h0;
        case (alu_f)
            4'h0: alu_d = ~alu_a;
            4'h1: alu_d = alu_a - alu_b - alu_cin;
            4'h2: alu_d = alu_a + alu_b + alu_cin;
            4'h3: alu_d = alu_a & alu_b;
            4'h4: alu_d = alu_a | alu_b;
            4'h5: alu_d = alu_a ^ alu_b;
            4'h6: alu_d = ~(alu_a ^ alu_b);
            4'h7: alu_d = alu_a * alu_b;
            4'h8: alu_d = (alu_b != 4'h0) ? alu_a / alu_b : 4'h0;
            4'h9: alu_d = alu_a << 1;
            4'hA: alu_d = alu_a >> 1;
            4'hB: alu_d = alu_a + 4'h1;
            4'hC: alu_d = alu_a - 4'h1;
            default: alu_d = 4'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(
        input logic [3:0] op, input logic [1:0] rd,
        input logic [1:0] ra, input logic [1:0] rb,
        input logic ui, input logic cin, input logic [3:0] imm);
        return {op, rd, ra, rb, ui, cin, imm};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #0.1;
            chk($sformatf("%s R%0d", tag, r), 16'(dbg_data), 16'(m_reg[r]));
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int w;

        vt[0]  = '{mk(4'h2,2'd1,2'd0,2'd0,1'b1,1'b1,4'h5), 4'h2,4'h0,4'h5,4'h1, 4'h6,2'd1,1'b0,3};
        vt[1]  = '{mk(4'h7,2'd2,2'd1,2'd0,1'b1,1'b0,4'h3), 4'h7,4'h6,4'h3,4'h0, 4'h2,2'd2,1'b0,3};
        vt[2]  = '{mk(4'hB,2'd2,2'd2,2'd0,1'b1,1'b0,4'h0), 4'hB,4'h2,4'h0,4'h0, 4'h3,2'd2,1'b0,3};
        vt[3]  = '{mk(4'hE,2'd3,2'd0,2'd0,1'b1,1'b0,4'h1), 4'hB,4'h2,4'h0,4'h0, 4'h0,2'd3,1'b1,1};
        vt[4]  = '{mk(4'h8,2'd3,2'd1,2'd0,1'b0,1'b0,4'h7), 4'hB,4'h2,4'h0,4'h0, 4'h0,2'd3,1'b1,1};
        vt[5]  = '{mk(4'h1,2'd0,2'd1,2'd2,1'b0,1'b1,4'h0), 4'h1,4'h6,4'h3,4'h1, 4'h2,2'd0,1'b0,3};
        vt[6]  = '{mk(4'h5,2'd3,2'd1,2'd0,1'b1,1'b0,4'hF), 4'h5,4'h6,4'hF,4'h0, 4'h9,2'd3,1'b0,3};
        vt[7]  = '{mk(4'h8,2'd1,2'd3,2'd0,1'b0,1'b0,4'h0), 4'h8,4'h9,4'h2,4'h0, 4'h4,2'd1,1'b0,3};
        vt[8]  = '{mk(4'h0,2'd2,2'd3,2'd0,1'b1,1'b0,4'h0), 4'h0,4'h9,4'h0,4'h0, 4'h6,2'd2,1'b0,3};
        vt[9]  = '{mk(4'h9,2'd0,2'd3,2'd0,1'b1,1'b0,4'h0), 4'h9,4'h9,4'h0,4'h0, 4'h2,2'd0,1'b0,3};
        vt[10] = '{mk(4'hC,2'd1,2'd1,2'd0,1'b1,1'b0,4'h0), 4'hC,4'h4,4'h0,4'h0, 4'h3,2'd1,1'b0,3};
        vt[11] = '{mk(4'hD,2'd0,2'd0,2'd0,1'b1,1'b0,4'h0), 4'hC,4'h4,4'h0,4'h0, 4'h0,2'd0,1'b1,1};
        vt[12] = '{mk(4'hA,2'd3,2'd3,2'd0,1'b1,1'b0,4'h0), 4'hA,4'h9,4'h0,4'h0, 4'h4,2'd3,1'b0,3};
        vt[13] = '{mk(4'h2,2'd2,2'd3,2'd0,1'b1,1'b1,4'hF), 4'h2,4'h4,4'hF,4'h1, 4'h4,2'd2,1'b0,3};
        vt[14] = '{mk(4'h8,2'd1,2'd2,2'd0,1'b1,1'b0,4'h0), 4'h2,4'h4,4'hF,4'h1, 4'h0,2'd1,1'b1,1};
        vt[15] = '{mk(4'h3,2'd0,2'd3,2'd0,1'b1,1'b0,4'h6), 4'h3,4'h4,4'h6,4'h0, 4'h4,2'd0,1'b0,3};
        vt[16] = '{mk(4'h4,2'd0,2'd0,2'd0,1'b1,1'b0,4'h3), 4'h4,4'h4,4'h3,4'h0, 4'h7,2'd0,1'b0,3};
        vt[17] = '{mk(4'h6,2'd3,2'd0,2'd1,1'b0,1'b0,4'h0), 4'h6,4'h7,4'h3,4'h0, 4'hB,2'd3,1'b0,3};

        for (int r = 0; r < 4; r++) m_reg[r] = 4'h0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        out_ready = 1'b1;
        dbg_sel   = 2'd0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        chk("reset out_valid", 16'(out_valid), 16'h0);
        chk("reset in_ready", 16'(in_ready), 16'h1);
        chk("reset out_data", 16'(out_data), 16'h0);
        chk("reset out_rd", 16'(out_rd), 16'h0);
        chk("reset out_err", 16'(out_err), 16'h0);
        chk("reset alu", {alu_f, alu_a, alu_b, alu_cin}, 16'h0);
        chk_regs("reset");

        for (int i = 0; i < 18; i++) begin
            w = 0;
            while (!in_ready && w < 8) begin
                step();
                w++;
            end
            chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'h1);
            in_instr = vt[i].instr;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            wait_resp(lat);
            chk($sformatf("v%0d latency", i), 16'(lat), 16'(vt[i].lat));
            chk($sformatf("v%0d out_data", i), 16'(out_data), 16'(vt[i].data));
            chk($sformatf("v%0d out_rd", i), 16'(out_rd), 16'(vt[i].rd));
            chk($sformatf("v%0d out_err", i), 16'(out_err), 16'(vt[i].err));
            chk($sformatf("v%0d alu f/a/b/cin", i),
                {alu_f, alu_a, alu_b, alu_cin},
                {vt[i].f, vt[i].a, vt[i].b, vt[i].cin});
            if (!vt[i].err) m_reg[vt[i].rd] = vt[i].data;
            chk_regs($sformatf("v%0d", i));
            step();
            chk($sformatf("v%0d out_valid drop", i), 16'(out_valid), 16'h0);
            chk($sformatf("v%0d back idle", i), 16'(in_ready), 16'h1);
        end

        // Backpressure: response held while out_ready stays low
        out_ready = 1'b0;
        in_instr  = mk(4'h2, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0, 4'h1);
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        wait_resp(lat);
        chk("bp latency", 16'(lat), 16'd3);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_instr = mk(4'hE, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0);
            chk($sformatf("bp%0d out_valid", k), 16'(out_valid), 16'h1);
            chk($sformatf("bp%0d out", k),
                {7'h0, out_err, 2'b00, out_rd, out_data}, 16'h000C);
            chk($sformatf("bp%0d in_ready", k), 16'(in_ready), 16'h0);
            step();
        end
        in_valid  = 1'b0;
        chk("bp hold end", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        step();
        chk("bp released", 16'(out_valid), 16'h0);
        repeat (2) step();
        chk("bp no stray accept", 16'(out_valid), 16'h0);
        m_reg[0] = 4'hC;
        chk_regs("bp");

        // Reset asserted while the instruction sits in ISSUE
        in_instr = mk(4'h2, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 4'h5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rst issue alu_f", 16'(alu_f), 16'h2);
        chk("rst issue alu_a", 16'(alu_a), 16'hC);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst async alu", {alu_f, alu_a, alu_b, alu_cin}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst out_valid", 16'(out_valid), 16'h0);
        chk("rst in_ready", 16'(in_ready), 16'h1);
        for (int r = 0; r < 4; r++) m_reg[r] = 4'h0;
        chk_regs("rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
